// File: rtl/collision_pkg.sv
// Shared types for the collision engine.
//   state_t  : scan sequencer states
//   coord_t  : 11-bit pixel coordinate
//   corner_t : tank footprint corner being probed (TL, TR, BL, BR)
package collision_pkg;

    typedef logic [10:0] coord_t;

    typedef enum logic [2:0] {
        IDLE,
        TANK,
        MISSILE,
        CLEAR,
        PUBLISH
    } state_t;

    typedef enum logic [1:0] {
        CORNER_TL,
        CORNER_TR,
        CORNER_BL,
        CORNER_BR
    } corner_t;

    function automatic logic corner_right(input corner_t c);
        return (c == CORNER_TR) || (c == CORNER_BR);
    endfunction

    function automatic logic corner_bottom(input corner_t c);
        return (c == CORNER_BL) || (c == CORNER_BR);
    endfunction

endpackage

// File: rtl/collision_engine_if.sv
// Brick-clear request channel between the collision engine and the brick-map owner.
//   clrValid  : request pending (engine -> owner)
//   clrRow    : row of the brick to clear
//   clrCol    : column of the brick to clear
//   clrReady  : owner accepts the request this cycle
// master = collision engine, slave = brick-map owner.
interface collision_engine_if #(
    parameter int ROW_W = 4,
    parameter int COL_W = 5
);
    logic             clrValid;
    logic [ROW_W-1:0] clrRow;
    logic [COL_W-1:0] clrCol;
    logic             clrReady;

    modport master (output clrValid, output clrRow, output clrCol, input clrReady);
    modport slave  (input clrValid, input clrRow, input clrCol, output clrReady);
endinterface

// File: rtl/brick_cell_lookup.sv
// Combinational point-to-brick-cell lookup, shared by the tank and missile paths.
//   point_x/y    : pixel point (12 bits so callers can add small offsets without wrap)
//   matrix_x/y   : matrix top-left in pixels
//   brick_matrix : live occupancy, [row][col]
//   row/col      : cell indices containing the point
//   in_matrix    : point lies at a non-negative offset inside the matrix
//   brick        : occupancy bit of that cell, 0 when outside the matrix
module brick_cell_lookup
    import collision_pkg::*;
#(
    parameter int MAT_ROWS = 14,
    parameter int MAT_COLS = 17,
    parameter int BRICK_W  = 32,
    parameter int BRICK_H  = 32,
    localparam int ROW_W   = $clog2(MAT_ROWS),
    localparam int COL_W   = $clog2(MAT_COLS)
) (
    input  logic [11:0]                        point_x,
    input  logic [11:0]                        point_y,
    input  coord_t                             matrix_x,
    input  coord_t                             matrix_y,
    input  logic [MAT_ROWS-1:0][MAT_COLS-1:0]  brick_matrix,
    output logic [ROW_W-1:0]                   row,
    output logic [COL_W-1:0]                   col,
    output logic                               in_matrix,
    output logic                               brick
);

    localparam int SHX = $clog2(BRICK_W);
    localparam int SHY = $clog2(BRICK_H);

    logic signed [12:0] off_x;
    logic signed [12:0] off_y;
    logic        [12:0] cell_c;
    logic        [12:0] cell_r;

    assign off_x  = $signed({1'b0, point_x}) - $signed({2'b00, matrix_x});
    assign off_y  = $signed({1'b0, point_y}) - $signed({2'b00, matrix_y});

    // Only meaningful when the offset is non-negative; negatives are rejected below.
    assign cell_c = off_x[12:0] >> SHX;
    assign cell_r = off_y[12:0] >> SHY;

    assign in_matrix = !off_x[12] && !off_y[12] &&
                       (cell_c < 13'(MAT_COLS)) && (cell_r < 13'(MAT_ROWS));

    assign row = cell_r[ROW_W-1:0];
    assign col = cell_c[COL_W-1:0];

    // Full compare against every cell so an out-of-range index never selects a bit.
    always_comb begin
        brick = 1'b0;
        for (int r = 0; r < MAT_ROWS; r++) begin
            for (int c = 0; c < MAT_COLS; c++) begin
                if (in_matrix && (cell_r == 13'(r)) && (cell_c == 13'(c))) begin
                    brick = brick_matrix[r][c];
                end
            end
        end
    end

endmodule

// File: rtl/collision_engine.sv
// Frame-sequenced collision engine. On startOfFrame it snapshots tank and missile
// positions, probes tank corners and missile centres against the brick matrix and
// the playfield bounds, turns missile-on-brick hits into clear requests, and
// publishes the per-object flags in one edge.
//   clk, resetN      : clock, async active-low reset
//   startOfFrame     : one-cycle scan request
//   tankX/Y          : tank top-left, per tank
//   missileX/Y       : missile top-left, per missile
//   missileActive    : missile in flight
//   brickMatrix      : live occupancy [row][col]
//   matrixX/Y        : matrix top-left
//   tankCollision    : per-tank flag, updated on publish
//   missileHit       : per-missile flag, updated on publish
//   clr              : brick-clear request channel (master)
//   busy             : scan in progress
//   done             : pulse when flags are published
//   overrun          : pulse when a startOfFrame arrives mid-scan
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for startOfFrame
// TANK    | one (tank, corner) probe per cycle, corners TL,TR,BL,BR
// MISSILE | one missile centre probe per cycle
// CLEAR   | holding a brick-clear request until clrReady
// PUBLISH | copy shadow flags to outputs, pulse done
module collision_engine
    import collision_pkg::*;
#(
    parameter int NUM_TANKS    = 2,
    parameter int NUM_MISSILES = 2,
    parameter int MAT_ROWS     = 14,
    parameter int MAT_COLS     = 17,
    parameter int BRICK_W      = 32,
    parameter int BRICK_H      = 32,
    parameter int TANK_W       = 32,
    parameter int TANK_H       = 32,
    parameter int MISSILE_W    = 10,
    parameter int MISSILE_H    = 10,
    parameter int SCR_LEFT     = 16,
    parameter int SCR_RIGHT    = 560,
    parameter int SCR_TOP      = 16,
    parameter int SCR_BOTTOM   = 464
) (
    input  logic                              clk,
    input  logic                              resetN,
    input  logic                              startOfFrame,
    input  coord_t                            tankX [NUM_TANKS],
    input  coord_t                            tankY [NUM_TANKS],
    input  coord_t                            missileX [NUM_MISSILES],
    input  coord_t                            missileY [NUM_MISSILES],
    input  logic [NUM_MISSILES-1:0]           missileActive,
    input  logic [MAT_ROWS-1:0][MAT_COLS-1:0] brickMatrix,
    input  coord_t                            matrixX,
    input  coord_t                            matrixY,
    output logic [NUM_TANKS-1:0]              tankCollision,
    output logic [NUM_MISSILES-1:0]           missileHit,
    collision_engine_if.master                clr,
    output logic                              busy,
    output logic                              done,
    output logic                              overrun
);

    localparam int ROW_W = $clog2(MAT_ROWS);
    localparam int COL_W = $clog2(MAT_COLS);
    localparam int TI_W  = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1;
    localparam int MI_W  = (NUM_MISSILES > 1) ? $clog2(NUM_MISSILES) : 1;
    localparam int SHX   = $clog2(BRICK_W);
    localparam int SHY   = $clog2(BRICK_H);

    state_t                   state_q, state_d;
    logic [TI_W-1:0]          tank_idx_q, tank_idx_d;
    corner_t                  corner_q, corner_d;
    logic [MI_W-1:0]          mis_idx_q, mis_idx_d;
    coord_t                   tank_x_q [NUM_TANKS];
    coord_t                   tank_x_d [NUM_TANKS];
    coord_t                   tank_y_q [NUM_TANKS];
    coord_t                   tank_y_d [NUM_TANKS];
    coord_t                   mis_x_q [NUM_MISSILES];
    coord_t                   mis_x_d [NUM_MISSILES];
    coord_t                   mis_y_q [NUM_MISSILES];
    coord_t                   mis_y_d [NUM_MISSILES];
    logic [NUM_MISSILES-1:0]  mis_act_q, mis_act_d;
    logic [NUM_TANKS-1:0]     tank_sh_q, tank_sh_d;
    logic [NUM_TANKS-1:0]     tank_col_q, tank_col_d;
    logic [NUM_MISSILES-1:0]  mis_sh_q, mis_sh_d;
    logic [NUM_MISSILES-1:0]  mis_hit_q, mis_hit_d;
    logic                     last_valid_q, last_valid_d;
    logic [ROW_W-1:0]         last_row_q, last_row_d;
    logic [COL_W-1:0]         last_col_q, last_col_d;
    logic [ROW_W-1:0]         clr_row_q, clr_row_d;
    logic [COL_W-1:0]         clr_col_q, clr_col_d;
    logic                     done_q, done_d;
    logic                     overrun_q, overrun_d;

    coord_t                   cur_tx, cur_ty, cur_mx, cur_my;
    logic [11:0]              tank_r, tank_b, mis_cx, mis_cy;
    logic [SHX-1:0]           rem_x;
    logic [SHY-1:0]           rem_y;
    logic                     need_x, need_y;
    logic                     corner_tested, corner_hit;
    logic                     tank_scr_out, mis_scr_out, same_cell;
    logic                     last_tank, last_missile;

    logic [11:0]              look_x, look_y;
    logic [ROW_W-1:0]         look_row;
    logic [COL_W-1:0]         look_col;
    logic                     look_in, look_brick;

    assign cur_tx = tank_x_q[tank_idx_q];
    assign cur_ty = tank_y_q[tank_idx_q];
    assign cur_mx = mis_x_q[mis_idx_q];
    assign cur_my = mis_y_q[mis_idx_q];

    assign tank_r = {1'b0, cur_tx} + 12'(TANK_W);
    assign tank_b = {1'b0, cur_ty} + 12'(TANK_H);
    assign mis_cx = {1'b0, cur_mx} + 12'(MISSILE_W / 2);
    assign mis_cy = {1'b0, cur_my} + 12'(MISSILE_H / 2);

    // Offset modulo the cell size depends only on the low bits of both operands.
    assign rem_x  = cur_tx[SHX-1:0] - matrixX[SHX-1:0];
    assign rem_y  = cur_ty[SHY-1:0] - matrixY[SHY-1:0];
    assign need_x = (int'(rem_x) + TANK_W) > BRICK_W;
    assign need_y = (int'(rem_y) + TANK_H) > BRICK_H;

    assign tank_scr_out = ({1'b0, cur_tx} < 12'(SCR_LEFT))  || (tank_r > 12'(SCR_RIGHT)) ||
                          ({1'b0, cur_ty} < 12'(SCR_TOP))   || (tank_b > 12'(SCR_BOTTOM));
    assign mis_scr_out  = (mis_cx < 12'(SCR_LEFT)) || (mis_cx > 12'(SCR_RIGHT)) ||
                          (mis_cy < 12'(SCR_TOP))  || (mis_cy > 12'(SCR_BOTTOM));

    assign last_tank    = (tank_idx_q == TI_W'(NUM_TANKS - 1));
    assign last_missile = (mis_idx_q == MI_W'(NUM_MISSILES - 1));

    // Tank footprint never exceeds one cell, so the right/bottom neighbour is
    // reached by moving the probe point exactly one cell width/height.
    always_comb begin
        look_x = {1'b0, cur_tx};
        look_y = {1'b0, cur_ty};
        if (state_q == MISSILE) begin
            look_x = mis_cx;
            look_y = mis_cy;
        end else begin
            if (corner_right(corner_q))  look_x = {1'b0, cur_tx} + 12'(BRICK_W);
            if (corner_bottom(corner_q)) look_y = {1'b0, cur_ty} + 12'(BRICK_H);
        end
    end

    brick_cell_lookup #(
        .MAT_ROWS (MAT_ROWS),
        .MAT_COLS (MAT_COLS),
        .BRICK_W  (BRICK_W),
        .BRICK_H  (BRICK_H)
    ) u_lookup (
        .point_x      (look_x),
        .point_y      (look_y),
        .matrix_x     (matrixX),
        .matrix_y     (matrixY),
        .brick_matrix (brickMatrix),
        .row          (look_row),
        .col          (look_col),
        .in_matrix    (look_in),
        .brick        (look_brick)
    );

    always_comb begin
        corner_tested = 1'b0;
        case (corner_q)
            CORNER_TL: corner_tested = 1'b1;
            CORNER_TR: corner_tested = need_x;
            CORNER_BL: corner_tested = need_y;
            CORNER_BR: corner_tested = need_x && need_y;
            default:   corner_tested = 1'b0;
        endcase
    end

    assign corner_hit = corner_tested && look_in && look_brick;
    assign same_cell  = last_valid_q && (look_row == last_row_q) && (look_col == last_col_q);

    always_comb begin
        state_d      = state_q;
        tank_idx_d   = tank_idx_q;
        corner_d     = corner_q;
        mis_idx_d    = mis_idx_q;
        tank_x_d     = tank_x_q;
        tank_y_d     = tank_y_q;
        mis_x_d      = mis_x_q;
        mis_y_d      = mis_y_q;
        mis_act_d    = mis_act_q;
        tank_sh_d    = tank_sh_q;
        tank_col_d   = tank_col_q;
        mis_sh_d     = mis_sh_q;
        mis_hit_d    = mis_hit_q;
        last_valid_d = last_valid_q;
        last_row_d   = last_row_q;
        last_col_d   = last_col_q;
        clr_row_d    = clr_row_q;
        clr_col_d    = clr_col_q;
        done_d       = 1'b0;
        overrun_d    = startOfFrame && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (startOfFrame) begin
                    tank_x_d     = tankX;
                    tank_y_d     = tankY;
                    mis_x_d      = missileX;
                    mis_y_d      = missileY;
                    mis_act_d    = missileActive;
                    tank_idx_d   = '0;
                    corner_d     = CORNER_TL;
                    mis_idx_d    = '0;
                    tank_sh_d    = '0;
                    mis_sh_d     = '0;
                    last_valid_d = 1'b0;
                    state_d      = TANK;
                end
            end

            TANK: begin
                if (corner_hit || ((corner_q == CORNER_TL) && tank_scr_out)) begin
                    tank_sh_d[tank_idx_q] = 1'b1;
                end
                if (corner_q == CORNER_BR) begin
                    corner_d = CORNER_TL;
                    if (last_tank) begin
                        state_d = MISSILE;
                    end else begin
                        tank_idx_d = tank_idx_q + 1'b1;
                    end
                end else begin
                    corner_d = corner_t'(corner_q + 2'd1);
                end
            end

            MISSILE: begin
                if (mis_act_q[mis_idx_q] && (mis_scr_out || (look_in && look_brick))) begin
                    mis_sh_d[mis_idx_q] = 1'b1;
                end
                if (mis_act_q[mis_idx_q] && !mis_scr_out && look_in && look_brick && !same_cell) begin
                    // Index advances only once the clear has been accepted.
                    clr_row_d = look_row;
                    clr_col_d = look_col;
                    state_d   = CLEAR;
                end else if (last_missile) begin
                    state_d = PUBLISH;
                end else begin
                    mis_idx_d = mis_idx_q + 1'b1;
                end
            end

            CLEAR: begin
                if (clr.clrReady) begin
                    last_valid_d = 1'b1;
                    last_row_d   = clr_row_q;
                    last_col_d   = clr_col_q;
                    if (last_missile) begin
                        state_d = PUBLISH;
                    end else begin
                        mis_idx_d = mis_idx_q + 1'b1;
                        state_d   = MISSILE;
                    end
                end
            end

            PUBLISH: begin
                tank_col_d = tank_sh_q;
                mis_hit_d  = mis_sh_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            tank_idx_q   <= '0;
            corner_q     <= CORNER_TL;
            mis_idx_q    <= '0;
            tank_x_q     <= '{default: '0};
            tank_y_q     <= '{default: '0};
            mis_x_q      <= '{default: '0};
            mis_y_q      <= '{default: '0};
            mis_act_q    <= '0;
            tank_sh_q    <= '0;
            tank_col_q   <= '0;
            mis_sh_q     <= '0;
            mis_hit_q    <= '0;
            last_valid_q <= 1'b0;
            last_row_q   <= '0;
            last_col_q   <= '0;
            clr_row_q    <= '0;
            clr_col_q    <= '0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tank_idx_q   <= tank_idx_d;
            corner_q     <= corner_d;
            mis_idx_q    <= mis_idx_d;
            tank_x_q     <= tank_x_d;
            tank_y_q     <= tank_y_d;
            mis_x_q      <= mis_x_d;
            mis_y_q      <= mis_y_d;
            mis_act_q    <= mis_act_d;
            tank_sh_q    <= tank_sh_d;
            tank_col_q   <= tank_col_d;
            mis_sh_q     <= mis_sh_d;
            mis_hit_q    <= mis_hit_d;
            last_valid_q <= last_valid_d;
            last_row_q   <= last_row_d;
            last_col_q   <= last_col_d;
            clr_row_q    <= clr_row_d;
            clr_col_q    <= clr_col_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
        end
    end

    // clrValid decodes straight from the state flop so reset removes it at once.
    assign clr.clrValid  = (state_q == CLEAR);
    assign clr.clrRow    = clr_row_q;
    assign clr.clrCol    = clr_col_q;
    assign tankCollision = tank_col_q;
    assign missileHit    = mis_hit_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_collision_engine.sv
module tb_collision_engine;
    import collision_pkg::*;

    logic                 clk = 1'b0;
    logic                 resetN;
    logic                 sof;
    coord_t               tank_x [2];
    coord_t               tank_y [2];
    coord_t               mis_x [2];
    coord_t               mis_y [2];
    logic [1:0]           mis_act;
    logic [13:0][16:0]    brick_matrix;
    coord_t               matrix_x, matrix_y;
    logic [1:0]           tank_coll;
    logic [1:0]           mis_hit;
    logic                 busy, done, overrun;

    int n_cmp = 0;
    int n_bad = 0;

    int stall_target = 0;
    int stall_cnt    = 0;
    int valid_cycles = 0;
    int hs_cnt       = 0;
    logic [3:0] seen_row;
    logic [4:0] seen_col;

    always #5 clk = ~clk;

    collision_engine_if #(.ROW_W(4), .COL_W(5)) clr_bus ();

    collision_engine dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (sof),
        .tankX         (tank_x),
        .tankY         (tank_y),
        .missileX      (mis_x),
        .missileY      (mis_y),
        .missileActive (mis_act),
        .brickMatrix   (brick_matrix),
        .matrixX       (matrix_x),
        .matrixY       (matrix_y),
        .tankCollision (tank_coll),
        .missileHit    (mis_hit),
        .clr           (clr_bus),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Brick-map owner: holds clrReady low for stall_target cycles of each request.
    initial begin
        clr_bus.clrReady = 1'b0;
        forever begin
            @(negedge clk);
            if (clr_bus.clrValid === 1'b1) begin
                if (stall_cnt == 0) begin
                    seen_row = clr_bus.clrRow;
                    seen_col = clr_bus.clrCol;
                end
                clr_bus.clrReady = (stall_cnt >= stall_target);
                stall_cnt++;
                valid_cycles++;
                if (clr_bus.clrReady) hs_cnt++;
            end else begin
                clr_bus.clrReady = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    task automatic set_tank(input int i, input int x, input int y);
        tank_x[i] = coord_t'(x);
        tank_y[i] = coord_t'(y);
    endtask

    task automatic set_mis(input int i, input int x, input int y, input logic act);
        mis_x[i]   = coord_t'(x);
        mis_y[i]   = coord_t'(y);
        mis_act[i] = act;
    endtask

    task automatic run_frame(input string tag, input int exp_lat,
                             input logic [1:0] exp_tank, input logic [1:0] exp_mis);
        int cnt;
        bit got;
        valid_cycles = 0;
        hs_cnt = 0;
        @(negedge clk);
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        cnt = 1;
        check_val({tag, "_busy_scan"}, 32'(busy), 32'd1);
        got = 1'b0;
        while (cnt < 200 && !got) begin
            @(negedge clk);
            cnt++;
            if (done) got = 1'b1;
        end
        check_val({tag, "_done_seen"}, 32'(got), 32'd1);
        check_val({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
        check_val({tag, "_tank"}, 32'(tank_coll), 32'(exp_tank));
        check_val({tag, "_missile"}, 32'(mis_hit), 32'(exp_mis));
        check_val({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int ov_cnt;
        int dn_cnt;
        bit got;
        resetN = 1'b0;
        sof = 1'b0;
        matrix_x = 11'd16;
        matrix_y = 11'd16;
        brick_matrix = '0;
        mis_act = 2'b00;
        set_tank(0, 240, 240);
        set_tank(1, 240, 240);
        set_mis(0, 100, 100, 1'b0);
        set_mis(1, 100, 100, 1'b0);

        #12;
        check_val("rst_tank", 32'(tank_coll), 32'd0);
        check_val("rst_missile", 32'(mis_hit), 32'd0);
        check_val("rst_clrvalid", 32'(clr_bus.clrValid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        resetN = 1'b1;

        // Tank0 aligned in cell (1,1) with a brick; tank1 over empty cells.
        set_tank(0, 48, 48);
        brick_matrix[1][1] = 1'b1;
        run_frame("t1_tl_brick", 12, 2'b01, 2'b00);

        // remX=12 reaches column 2 through TR; remY=0 never probes row 2.
        set_tank(0, 60, 48);
        brick_matrix = '0;
        brick_matrix[1][2] = 1'b1;
        run_frame("t2_tr_brick", 12, 2'b01, 2'b00);
        brick_matrix = '0;
        brick_matrix[2][1] = 1'b1;
        run_frame("t2_bl_untested", 12, 2'b00, 2'b00);

        // Screen bounds on an empty matrix.
        brick_matrix = '0;
        set_tank(0, 8, 100);
        run_frame("t3_left", 12, 2'b01, 2'b00);
        set_tank(0, 530, 100);
        run_frame("t3_right", 12, 2'b01, 2'b00);
        set_tank(0, 528, 100);
        set_tank(1, 240, 440);
        run_frame("t3_edge_bottom", 12, 2'b10, 2'b00);

        // Missile on brick (2,2) with owner stalling 3 cycles.
        set_tank(0, 240, 240);
        set_tank(1, 240, 240);
        brick_matrix[2][2] = 1'b1;
        set_mis(0, 100, 100, 1'b1);
        stall_target = 3;
        run_frame("t4_stall", 16, 2'b00, 2'b01);
        check_val("t4_valid_cycles", 32'(valid_cycles), 32'd4);
        check_val("t4_handshakes", 32'(hs_cnt), 32'd1);
        check_val("t4_row", 32'(seen_row), 32'd2);
        check_val("t4_col", 32'(seen_col), 32'd2);

        // Two missiles centred in the same cell: one request only.
        stall_target = 0;
        set_tank(0, 8, 100);
        set_mis(1, 90, 90, 1'b1);
        run_frame("t5_same_cell", 13, 2'b01, 2'b11);
        check_val("t5_handshakes", 32'(hs_cnt), 32'd1);

        // Reset while a clear request is stalled.
        set_mis(1, 90, 90, 1'b0);
        stall_target = 1000;
        @(negedge clk);
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (clr_bus.clrValid) got = 1'b1;
        end
        check_val("t6_clr_reached", 32'(got), 32'd1);
        resetN = 1'b0;
        #1;
        check_val("t6_clrvalid_drop", 32'(clr_bus.clrValid), 32'd0);
        check_val("t6_tank_clear", 32'(tank_coll), 32'd0);
        check_val("t6_missile_clear", 32'(mis_hit), 32'd0);
        check_val("t6_busy_clear", 32'(busy), 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        stall_target = 0;

        // After reset the same cell is requested again.
        set_tank(0, 240, 240);
        run_frame("t7_post_reset", 13, 2'b00, 2'b01);
        check_val("t7_handshakes", 32'(hs_cnt), 32'd1);

        // Centre left of the screen: hit without a request; inactive missile on a brick.
        set_mis(0, 5, 100, 1'b1);
        set_mis(1, 90, 90, 1'b0);
        run_frame("t8_offscreen", 12, 2'b00, 2'b01);
        check_val("t8_handshakes", 32'(hs_cnt), 32'd0);

        // Second startOfFrame three cycles into a scan.
        brick_matrix = '0;
        set_mis(0, 5, 100, 1'b0);
        @(negedge clk);
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        repeat (2) @(negedge clk);
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        check_val("t9_overrun_pulse", 32'(overrun), 32'd1);
        ov_cnt = 1;
        dn_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (overrun) ov_cnt++;
            if (done) dn_cnt++;
        end
        check_val("t9_overrun_count", 32'(ov_cnt), 32'd1);
        check_val("t9_done_count", 32'(dn_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/collision_engine.md
# collision_engine

Frame-sequenced collision engine for BattleCity: on each frame strobe it snapshots up to NUM_TANKS tank and NUM_MISSILES missile positions. It scans them against the brick occupancy matrix and the playfield bounds, then publishes per-object collision flags atomically. Missile-on-brick hits are turned into brick-clear requests over a valid/ready handshake to the brick-map owner. It sits between the object movement blocks and the brick matrix / drawing logic.

## Interface
- NUM_TANKS, 2, tanks scanned per frame (1..4)
- NUM_MISSILES, 2, missiles scanned per frame (1..8)
- MAT_ROWS, 14 / MAT_COLS, 17, brick matrix dimensions
- BRICK_W, 32 / BRICK_H, 32, brick cell size in pixels; power of two
- TANK_W, 32 / TANK_H, 32, tank footprint; must be ≤ BRICK_W / BRICK_H
- MISSILE_W, 10 / MISSILE_H, 10, missile footprint
- SCR_LEFT, 16 / SCR_RIGHT, 560 / SCR_TOP, 16 / SCR_BOTTOM, 464, playfield bounds in pixels
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle scan request
- tankX, tankY  in  [NUM_TANKS][11]  tank top-left
- missileX, missileY  in  [NUM_MISSILES][11]  missile top-left
- missileActive  in  NUM_MISSILES  missile in flight
- brickMatrix  in  [MAT_ROWS][MAT_COLS]  occupancy, read live
- matrixX, matrixY  in  11  matrix top-left
- tankCollision  out  NUM_TANKS  registered, per frame
- missileHit  out  NUM_MISSILES  registered, per frame
- clrValid  out  1  brick-clear request
- clrRow  out  $clog2(MAT_ROWS)  brick-clear request row
- clrCol  out  $clog2(MAT_COLS)  brick-clear request column
- clrReady  in  1  brick-map owner accepts the clear
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse when flags are published
- overrun  out  1  one-cycle pulse when startOfFrame is dropped

## Operation
- States: IDLE, TANK, MISSILE, CLEAR, PUBLISH.
- IDLE: on startOfFrame, snapshot all tank and missile coordinates and missileActive, then go to TANK. Indices reset to 0. Shadow flags are cleared.
- TANK: one (tank, corner) pair per cycle, corners in order TL, TR, BL, BR.
  - offX = tankX − matrixX and offY = tankY − matrixY, 12-bit signed.
  - col = offX >> log2(BRICK_W); row = offY >> log2(BRICK_H).
  - Right or bottom neighbour cells are tested only if (offX mod BRICK_W) + TANK_W > BRICK_W, or (offY mod BRICK_H) + TANK_H > BRICK_H, respectively. Untested corners evaluate 0.
  - A cell with negative offset or outside the matrix reads as empty.
  - Screen test on the TL cycle: X < SCR_LEFT, X+TANK_W > SCR_RIGHT, Y < SCR_TOP, or Y+TANK_H > SCR_BOTTOM sets the shadow flag.
- MISSILE: one missile per cycle, using its centre point (X+MISSILE_W/2, Y+MISSILE_H/2).
  - Inactive missile: flag 0.
  - Centre outside the screen bounds: hit, no clear request.
  - Brick present at the centre cell: hit; go to CLEAR unless that cell equals the last cell cleared this frame, in which case it is a hit with no request.
- CLEAR: clrValid=1 with clrRow/clrCol stable until clrReady is sampled high. Then record the cleared cell, advance, and return to MISSILE, or to PUBLISH after the last missile.
- PUBLISH: copy shadow flags to the outputs, pulse done, go to IDLE.
- startOfFrame while not IDLE: ignored, overrun pulses.

## Timing
- Reset values: all outputs 0, state IDLE, last-cleared cell invalid. Reset mid-scan aborts immediately, and clrValid drops asynchronously.
- Latency with no clear stalls: startOfFrame sampled at edge k → done high in the cycle after edge k + 4·NUM_TANKS + NUM_MISSILES + 1.
- Each CLEAR adds ≥1 cycle per request, plus every cycle that clrReady is low.
- tankCollision and missileHit change only on the PUBLISH edge and hold until the next PUBLISH.
- busy is high from the snapshot edge through the PUBLISH cycle.

## Structure
- collision_pkg holds:
  - state_t enum
  - coord_t (logic [10:0])
  - the corner encoding
- Sub-module brick_cell_lookup (combinational): point → row, col, inMatrix, brick bit. It is shared by the tank and missile paths.

## Test plan
- Tank0 at (48,48), matrix at (16,16), brick[1][1]=1 → tankCollision[0]=1 on the done cycle; tank1 at (240,240) with empty cells → tankCollision[1]=0.
- Tank0 at (60,48), only brick[1][2]=1 → collision through the TR corner; same position with only brick[2][1]=1 → 0, since remY=0.
- Tank0 at (8,100), empty matrix → collision from the screen-left bound; tank at (530,100) → collision because 562 > 560.
- Missile0 active at (100,100), brick[2][2]=1, clrReady low for 3 cycles → clrValid held 4 cycles with row 2, col 2; missileHit[0]=1; done delayed 4 cycles.
- Both missiles centred in cell (2,2) → exactly one clear request; missileHit=2'b11.
- startOfFrame pulsed again 3 cycles after the first → overrun pulse, exactly one done; resetN low mid-CLEAR → clrValid=0 immediately, all flags 0.
